conv_out_stage: RTL and testbench

CONV_OUT_STAGE -- requirements
Module: conv_out_stage

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_requant.sv | 47 ++++
 rtl/conv_out_stage.sv | 127 ++++++++++++
 tb/tb_conv_out_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, default parameters and saturation bounds for conv_out_stage
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } conv_state_t;

    localparam int DEF_N_CH     = 4;
    localparam int DEF_N_COL    = 24;
    localparam int DEF_PSUM_W   = 14;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_PIPE_LAT = 5;
    localparam int DEF_ROWS     = 32;

    function automatic int out_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int out_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - single-lane requantisation: round (CONV_OUT_ROUND_EN), shift, relu, saturate
module conv_requant
    import conv_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic [PSUM_W-1:0] i_psum,
    input  logic [3:0]        i_shift,
    input  logic              i_relu_en,
    output logic [OUT_W-1:0]  o_act
);

    localparam int IW = PSUM_W + 1;

    logic signed [IW-1:0] w_ext;
    logic signed [IW-1:0] w_shr;
    logic signed [IW-1:0] w_rel;
    logic signed [31:0]   w_wide;

    assign w_ext = {i_psum[PSUM_W-1], i_psum};

`ifdef CONV_OUT_ROUND_EN
    logic        [IW-1:0] w_half;
    logic signed [IW-1:0] w_rnd;

    assign w_half = (i_shift == 4'd0) ? '0 : (IW'(1) << (i_shift - 4'd1));
    assign w_rnd  = w_ext + $signed(w_half);
    // Past PSUM_W every rounded lane lands on zero, and the half-LSB no longer fits IW bits.
    assign w_shr  = (int'(i_shift) > PSUM_W) ? '0 : (w_rnd >>> i_shift);
`else
    assign w_shr  = w_ext >>> i_shift;
`endif

    assign w_rel  = (i_relu_en && w_shr[IW-1]) ? '0 : w_shr;
    assign w_wide = 32'(w_rel);

    always_comb begin
        o_act = w_rel[OUT_W-1:0];
        if (w_wide > out_max(OUT_W)) begin
            o_act = OUT_W'(out_max(OUT_W));
        end else if (w_wide < out_min(OUT_W)) begin
            o_act = OUT_W'(out_min(OUT_W));
        end
    end

endmodule

// File: rtl/conv_out_stage.sv
// rtl/conv_out_stage.sv - conv-core output stage: fill latency, row capture/requant, backpressure
// Rounding mode selected by macro CONV_OUT_ROUND_EN (undefined: truncation).
module conv_out_stage
    import conv_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int N_COL    = DEF_N_COL,
    parameter int PSUM_W   = DEF_PSUM_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int ROWS     = DEF_ROWS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic                          i_din_vald,
    input  logic [N_CH*N_COL*PSUM_W-1:0]  i_psum_in,
    input  logic [3:0]                    i_shift,
    input  logic                          i_relu_en,
    output logic                          o_core_en,
    output logic [N_CH*N_COL*OUT_W-1:0]   o_dout,
    output logic                          o_dout_vald,
    input  logic                          i_dout_rdy,
    output logic                          o_dout_last,
    output logic                          o_busy,
    output logic                          o_frame_err
);

    localparam int LANES = N_CH * N_COL;
    localparam int LAT_W = $clog2(PIPE_LAT + 1);
    localparam int ROW_W = $clog2(ROWS + 1);

    conv_state_t                r_state;
    conv_state_t                w_state_nxt;
    logic [LAT_W-1:0]           r_lat_cnt;
    logic [ROW_W-1:0]           r_row_cnt;
    logic [3:0]                 r_shift;
    logic                       r_relu_en;
    logic [LANES*OUT_W-1:0]     r_dout;
    logic                       r_dout_vald;
    logic                       r_dout_last;
    logic                       r_frame_err;
    logic [LANES*OUT_W-1:0]     w_act;
    logic                       w_core_en;
    logic                       w_hs;
    logic                       w_start;
    logic                       w_capture;

    assign w_core_en = i_en & ~(r_dout_vald & ~i_dout_rdy);
    assign w_hs      = r_dout_vald & i_dout_rdy;
    assign w_start   = (r_state == ST_IDLE) & i_din_vald & i_en;
    assign w_capture = (r_state == ST_STREAM) & w_core_en & (r_row_cnt < ROW_W'(ROWS));

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            conv_requant #(
                .PSUM_W (PSUM_W),
                .OUT_W  (OUT_W)
            ) u_requant (
                .i_psum    (i_psum_in[g*PSUM_W +: PSUM_W]),
                .i_shift   (r_shift),
                .i_relu_en (r_relu_en),
                .o_act     (w_act[g*OUT_W +: OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The din_vald cycle is itself the first core-enabled latency cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = (PIPE_LAT <= 1) ? ST_STREAM : ST_FILL;
            ST_FILL:   if (w_core_en && (r_lat_cnt >= LAT_W'(PIPE_LAT - 1))) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_hs && r_dout_last) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt   <= '0;
            r_row_cnt   <= '0;
            r_shift     <= '0;
            r_relu_en   <= 1'b0;
            r_dout      <= '0;
            r_dout_vald <= 1'b0;
            r_dout_last <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= i_din_vald & (r_state != ST_IDLE);
            if (w_start) begin
                r_shift   <= i_shift;
                r_relu_en <= i_relu_en;
                r_lat_cnt <= LAT_W'(1);
                r_row_cnt <= '0;
            end else if ((r_state == ST_FILL) && w_core_en) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (w_capture) begin
                r_dout      <= w_act;
                r_dout_vald <= 1'b1;
                r_dout_last <= (r_row_cnt == ROW_W'(ROWS - 1));
                r_row_cnt   <= r_row_cnt + ROW_W'(1);
            end else if (w_hs) begin
                r_dout_vald <= 1'b0;
                r_dout_last <= 1'b0;
            end
        end
    end

    assign o_core_en   = w_core_en;
    assign o_dout      = r_dout;
    assign o_dout_vald = r_dout_vald;
    assign o_dout_last = r_dout_last;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_conv_out_stage.sv
// tb/tb_conv_out_stage.sv - randomized self-checking bench for conv_out_stage with a row scoreboard
module tb_conv_out_stage;

    localparam int N_CH     = 4;
    localparam int N_COL    = 24;
    localparam int PSUM_W   = 14;
    localparam int OUT_W    = 8;
    localparam int PIPE_LAT = 5;
    localparam int ROWS     = 32;
    localparam int L        = N_CH * N_COL;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  en = 1'b0;
    logic                  din_vald = 1'b0;
    logic [L*PSUM_W-1:0]   psum_in = '0;
    logic [3:0]            shift = 4'd0;
    logic                  relu_en = 1'b0;
    logic                  dout_rdy = 1'b0;
    logic                  core_en;
    logic [L*OUT_W-1:0]    dout;
    logic                  dout_vald;
    logic                  dout_last;
    logic                  busy;
    logic                  frame_err;

    conv_out_stage #(
        .N_CH (N_CH), .N_COL (N_COL), .PSUM_W (PSUM_W),
        .OUT_W (OUT_W), .PIPE_LAT (PIPE_LAT), .ROWS (ROWS)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_en (en), .i_din_vald (din_vald),
        .i_psum_in (psum_in), .i_shift (shift), .i_relu_en (relu_en),
        .o_core_en (core_en), .o_dout (dout), .o_dout_vald (dout_vald),
        .i_dout_rdy (dout_rdy), .o_dout_last (dout_last), .o_busy (busy),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: rows the core has handed over but downstream has not yet accepted.
    logic [L*OUT_W-1:0] exp_q[$];
    int                 exp_idx_q[$];
    bit                 m_busy = 0;
    bit                 m_relu = 0;
    bit                 exp_ferr = 0;
    bit                 m_first_pend = 0;
    bit                 chk_first = 0;
    bit                 use_dir = 0;
    int                 m_core_cnt = 0;
    int                 m_sent = 0;
    int                 m_rcvd = 0;
    int                 m_shift = 0;
    int                 cyc = 0;
    int                 start_cyc = 0;
    logic [L*PSUM_W-1:0] dir_row;
    logic [L*OUT_W-1:0]  first_row_out;

    function automatic int requant(input int p, input int sh, input bit relu);
        int v, d, q;
        v = p;
        d = 1 << sh;
`ifdef CONV_OUT_ROUND_EN
        if (sh > 0) v = v + d / 2;
`endif
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > (1 << (OUT_W - 1)) - 1) q = (1 << (OUT_W - 1)) - 1;
        if (q < -(1 << (OUT_W - 1))) q = -(1 << (OUT_W - 1));
        return q;
    endfunction

    function automatic logic [L*OUT_W-1:0] requant_row(input logic [L*PSUM_W-1:0] p, input int sh, input bit relu);
        logic [L*OUT_W-1:0] r;
        int v;
        for (int k = 0; k < L; k++) begin
            v = int'($signed(p[(L-1-k)*PSUM_W +: PSUM_W]));
            r[(L-1-k)*OUT_W +: OUT_W] = OUT_W'(requant(v, sh, relu));
        end
        return r;
    endfunction

    function automatic int lane_of(input logic [L*OUT_W-1:0] r, input int k);
        return int'($signed(r[(L-1-k)*OUT_W +: OUT_W]));
    endfunction

    function automatic logic [L*PSUM_W-1:0] rand_row();
        logic [L*PSUM_W-1:0] r;
        int s;
        for (int k = 0; k < L; k++) begin
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
            r[k*PSUM_W +: PSUM_W] = PSUM_W'(s);
        end
        return r;
    endfunction

    task automatic set_dir(input int a, input int b, input int c);
        dir_row = rand_row();
        dir_row[(L-1)*PSUM_W +: PSUM_W] = PSUM_W'(a);
        dir_row[(L-2)*PSUM_W +: PSUM_W] = PSUM_W'(b);
        dir_row[(L-3)*PSUM_W +: PSUM_W] = PSUM_W'(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_vald = 1'b0;
        dout_rdy = 1'b0;
        #1;
        check_eq("rst_dout", dout, '0);
        check_eq("rst_vald", dout_vald, 0);
        check_eq("rst_last", dout_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_core_en", core_en, en);
        exp_q.delete();
        exp_idx_q.delete();
        m_busy = 0;
        exp_ferr = 0;
        m_first_pend = 0;
        @(negedge clk);
        cyc++;
        check_eq("rst_hold_busy", busy, 0);
        check_eq("rst_hold_vald", dout_vald, 0);
        rst_n = 1'b1;
    endtask

    // Called at a negedge: check what the last edge produced, drive the next cycle, advance the model.
    task automatic step(input bit ven, input bit vrdy, input bit vdin);
        logic exp_ce;
        bit   old_busy;
        logic [L*PSUM_W-1:0] row;
        check_eq("busy", busy, m_busy);
        check_eq("frame_err", frame_err, exp_ferr);
        check_eq("dout_vald", dout_vald, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("dout", dout, exp_q[0]);
            check_eq("dout_last", dout_last, exp_idx_q[0] == ROWS - 1);
            if (m_first_pend) begin
                m_first_pend = 0;
                check_eq("first_lat", cyc - start_cyc, PIPE_LAT + 1);
            end
        end else begin
            check_eq("dout_last_idle", dout_last, 0);
        end
        row = (use_dir && m_busy && m_sent == 0) ? dir_row : rand_row();
        en = ven;
        dout_rdy = vrdy;
        din_vald = vdin;
        psum_in = row;
        #1;
        exp_ce = ven && !(exp_q.size() != 0 && !vrdy);
        check_eq("core_en", core_en, exp_ce);
        old_busy = m_busy;
        exp_ferr = vdin && old_busy;
        if (exp_q.size() != 0 && vrdy) begin
            if (exp_idx_q[0] == 0) first_row_out = dout;
            if (exp_idx_q[0] == ROWS - 1) m_busy = 0;
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
            m_rcvd++;
        end
        if (old_busy && exp_ce && m_core_cnt >= PIPE_LAT && m_sent < ROWS) begin
            exp_q.push_back(requant_row(row, m_shift, m_relu));
            exp_idx_q.push_back(m_sent);
            m_sent++;
        end
        if (old_busy && exp_ce) m_core_cnt++;
        if (!old_busy && vdin && ven) begin
            m_busy = 1;
            m_core_cnt = 1;
            m_sent = 0;
            m_rcvd = 0;
            m_shift = int'(shift);
            m_relu = relu_en;
            start_cyc = cyc;
            m_first_pend = chk_first;
        end
        @(negedge clk);
        cyc++;
    endtask

    // mode 0: steady; 1: random en/rdy/shift; 2: stall at row 10; 3: stray din_vald; 4: reset at row 12
    task automatic run_frame(input int mode, input int sh, input bit rl);
        int budget = 3000;
        int stall_n = 0;
        bit stray_done = 0;
        bit aborted = 0;
        bit ven, vrdy, vdin;
        logic [L*OUT_W-1:0] stall_dout = '0;
        shift = 4'(sh);
        relu_en = rl;
        step(1'b1, 1'b1, 1'b1);
        while (m_busy && budget > 0) begin
            budget--;
            ven = 1'b1;
            vrdy = 1'b1;
            vdin = 1'b0;
            if (mode == 1) begin
                ven = ($urandom_range(0, 3) != 0);
                vrdy = ($urandom_range(0, 2) != 0);
                vdin = ($urandom_range(0, 15) == 0);
                shift = 4'($urandom);
                relu_en = 1'($urandom);
            end
            if (mode == 2 && exp_q.size() != 0 && exp_idx_q[0] == 10 && stall_n < 3) begin
                if (stall_n == 0) stall_dout = dout;
                else check_eq("stall_hold", dout, stall_dout);
                stall_n++;
                vrdy = 1'b0;
            end
            if (mode == 3) begin
                if (m_rcvd == 8 && !stray_done) begin
                    vdin = 1'b1;
                    stray_done = 1;
                end
                if (exp_q.size() != 0 && exp_idx_q[0] == ROWS - 1) vdin = 1'b1;
            end
            if (mode == 4 && m_rcvd == 12) begin
                do_reset();
                aborted = 1;
                break;
            end
            step(ven, vrdy, vdin);
        end
        if (budget == 0) check_eq("frame_timeout", 0, 1);
        if (!aborted) check_eq("rows", m_rcvd, ROWS);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        en = 1'b1;
        do_reset();
        en = 1'b0;
        #1;
        check_eq("core_en_en0", core_en, 0);
        @(negedge clk);
        cyc++;

        use_dir = 1;
        chk_first = 1;
        set_dir(100, 300, -300);
        run_frame(0, 0, 0);
        check_eq("lane_100", lane_of(first_row_out, 0), 100);
        check_eq("lane_300", lane_of(first_row_out, 1), 127);
        check_eq("lane_m300", lane_of(first_row_out, 2), -128);

        set_dir(20, -20, 0);
        run_frame(0, 3, 0);
`ifdef CONV_OUT_ROUND_EN
        check_eq("lane_20_sh3", lane_of(first_row_out, 0), 3);
        check_eq("lane_m20_sh3", lane_of(first_row_out, 1), -2);
`else
        check_eq("lane_20_sh3", lane_of(first_row_out, 0), 2);
        check_eq("lane_m20_sh3", lane_of(first_row_out, 1), -3);
`endif

        set_dir(-5, 5, 0);
        run_frame(0, 0, 1);
        check_eq("relu_m5", lane_of(first_row_out, 0), 0);
        check_eq("relu_5", lane_of(first_row_out, 1), 5);

        use_dir = 0;
        run_frame(2, 2, 0);
        run_frame(3, 1, 1);
        run_frame(4, 0, 0);
        run_frame(0, 4, 0);

        chk_first = 0;
        for (int i = 0; i < 4; i++) begin
            run_frame(1, int'($urandom_range(0, 15)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
